// File: rtl/control_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : control_sequencer_pkg                                        |
// | Description : Shared state encoding, opcodes and IR field positions.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam int C_OPCODE_MSB = 31;
    localparam int C_OPCODE_LSB = 27;
    localparam int C_RA_MSB     = 26;
    localparam int C_RA_LSB     = 23;
    localparam int C_RB_MSB     = 22;
    localparam int C_RB_LSB     = 19;
    localparam int C_RC_MSB     = 18;
    localparam int C_RC_LSB     = 15;

    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_SHR  = 5'b00111;
    localparam logic [4:0] C_OP_SHL  = 5'b01000;
    localparam logic [4:0] C_OP_ROR  = 5'b01001;
    localparam logic [4:0] C_OP_ROL  = 5'b01010;
    localparam logic [4:0] C_OP_MUL  = 5'b01111;
    localparam logic [4:0] C_OP_DIV  = 5'b10000;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    // Two-operand ops whose single result is written back to Ra.
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op == C_OP_ADD) || (op == C_OP_SUB) || (op == C_OP_AND) ||
               (op == C_OP_OR)  || (op == C_OP_SHR) || (op == C_OP_SHL) ||
               (op == C_OP_ROR) || (op == C_OP_ROL);
    endfunction

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == C_OP_MUL) || (op == C_OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_reg_select_decoder.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_select_decoder                                           |
// | Description : 4-bit register field plus enable to 16-bit one-hot select.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_select_decoder (
    input  logic [3:0]  i_field,
    input  logic        i_en,
    output logic [15:0] o_onehot
);

    generate
        for (genvar g = 0; g < 16; g++) begin : g_bit
            assign o_onehot[g] = i_en && (i_field == 4'(g));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : control_sequencer                                            |
// | Description : Moore FSM issuing Datapath strobes for fetch/decode/execute. |
// |               Define CTRL_MULDIV_EN to enable the MUL/DIV (HI/LO) path.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        Clear,
    input  logic        Run,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhiout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [4:0]  ALU_op,
    output logic        Done,
    output logic        Halted
);

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_muldiv;
    logic        w_exec_ok;
    logic        w_rout_en;
    logic [3:0]  w_rout_sel;
    logic        w_rin_en;
    logic [3:0]  w_rin_sel;
    logic        w_unused;

    assign w_opcode = IR[C_OPCODE_MSB:C_OPCODE_LSB];
    assign w_ra     = IR[C_RA_MSB:C_RA_LSB];
    assign w_rb     = IR[C_RB_MSB:C_RB_LSB];
    assign w_rc     = IR[C_RC_MSB:C_RC_LSB];
    assign w_unused = ^IR[C_RC_LSB-1:0];

`ifdef CTRL_MULDIV_EN
    assign w_muldiv = is_muldiv_op(w_opcode);
`else
    assign w_muldiv = 1'b0;
`endif

    assign w_exec_ok = is_alu_op(w_opcode) || w_muldiv;

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        PCout        = 1'b0;
        MARin        = 1'b0;
        IncPC        = 1'b0;
        Zin          = 1'b0;
        Zlowout      = 1'b0;
        Zhiout       = 1'b0;
        PCin         = 1'b0;
        Read         = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        HIin         = 1'b0;
        LOin         = 1'b0;
        ALU_op       = 5'b00000;
        Done         = 1'b0;
        Halted       = 1'b0;
        w_rout_en    = 1'b0;
        w_rout_sel   = 4'd0;
        w_rin_en     = 1'b0;
        w_rin_sel    = 4'd0;

        case (r_state)
            S_IDLE: begin
                if (Run) begin
                    w_next_state = S_T0;
                end
            end
            S_T0: begin
                PCout        = 1'b1;
                MARin        = 1'b1;
                IncPC        = 1'b1;
                Zin          = 1'b1;
                w_next_state = S_T1;
            end
            S_T1: begin
                // Strobes stay up for the whole memory wait.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (Mem_ready) begin
                    w_next_state = S_T2;
                end
            end
            S_T2: begin
                MDRout       = 1'b1;
                IRin         = 1'b1;
                w_next_state = S_T3;
            end
            S_T3: begin
                if (w_exec_ok) begin
                    w_rout_en    = 1'b1;
                    w_rout_sel   = w_rb;
                    Yin          = 1'b1;
                    w_next_state = S_T4;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            S_T4: begin
                w_rout_en    = 1'b1;
                w_rout_sel   = w_rc;
                Zin          = 1'b1;
                ALU_op       = w_opcode;
                w_next_state = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_muldiv) begin
                    LOin         = 1'b1;
                    w_next_state = S_T6;
                end else begin
                    w_rin_en     = 1'b1;
                    w_rin_sel    = w_ra;
                    Done         = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_T6: begin
`ifdef CTRL_MULDIV_EN
                Zhiout = 1'b1;
                HIin   = 1'b1;
                Done   = 1'b1;
`endif
                w_next_state = S_IDLE;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    reg_select_decoder u_rout_dec (
        .i_field  (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    reg_select_decoder u_rin_dec (
        .i_field  (w_rin_sel),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                         |
// | Description : Scoreboard bench for control_sequencer (CTRL_MULDIV_EN aware)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_control_sequencer;

    localparam int ST_IDLE = 0;
    localparam int ST_T0   = 1;
    localparam int ST_T1   = 2;
    localparam int ST_T2   = 3;
    localparam int ST_T3   = 4;
    localparam int ST_T4   = 5;
    localparam int ST_T5   = 6;
    localparam int ST_T6   = 7;
    localparam int ST_HALT = 8;

    logic        clk = 1'b0;
    logic        Clear;
    logic        Run;
    logic        Mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin, Done, Halted;
    logic [15:0] Rout, Rin;
    logic [4:0]  ALU_op;

    int checks = 0;
    int errors = 0;

    logic [52:0] sb_val[$];
    string       sb_name[$];
    logic [52:0] act;

    assign act = {PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read,
                  MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin, ALU_op, Done, Halted};

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk       (clk),
        .Clear     (Clear),
        .Run       (Run),
        .Mem_ready (Mem_ready),
        .IR        (IR),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Zhiout    (Zhiout),
        .PCin      (PCin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rout      (Rout),
        .Rin       (Rin),
        .ALU_op    (ALU_op),
        .Done      (Done),
        .Halted    (Halted)
    );

    function automatic logic tb_alu(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd10);
    endfunction

    function automatic logic tb_md(input logic [4:0] op);
`ifdef CTRL_MULDIV_EN
        return (op == 5'b01111) || (op == 5'b10000);
`else
        return 1'b0;
`endif
    endfunction

    // Expected output vector for a state, built from the instruction fields.
    function automatic logic [52:0] model(input int st, input logic [31:0] ir);
        logic [13:0] s;
        logic [15:0] ro, ri;
        logic [4:0]  alu, op;
        logic        dn, hl;
        s = '0; ro = '0; ri = '0; alu = '0; dn = 1'b0; hl = 1'b0;
        op = ir[31:27];
        // s bits: 13 PCout,12 MARin,11 IncPC,10 Zin,9 Zlowout,8 Zhiout,7 PCin,
        //         6 Read,5 MDRin,4 MDRout,3 IRin,2 Yin,1 HIin,0 LOin
        case (st)
            ST_T0: s = 14'b1111_0000_0000_00;
            ST_T1: s = 14'b0000_1011_1000_00;
            ST_T2: s = 14'b0000_0000_0110_00;
            ST_T3: if (tb_alu(op) || tb_md(op)) begin
                       s[2] = 1'b1;
                       ro = 16'h1 << ir[22:19];
                   end
            ST_T4: begin
                       s[10] = 1'b1;
                       ro = 16'h1 << ir[18:15];
                       alu = op;
                   end
            ST_T5: begin
                       s[9] = 1'b1;
                       if (tb_md(op)) s[0] = 1'b1;
                       else begin
                           ri = 16'h1 << ir[26:23];
                           dn = 1'b1;
                       end
                   end
            ST_T6: begin
                       s[8] = 1'b1;
                       s[1] = 1'b1;
                       dn = 1'b1;
                   end
            ST_HALT: hl = 1'b1;
            default: ;
        endcase
        return {s, ro, ri, alu, dn, hl};
    endfunction

    function automatic void push(input string n, input logic [52:0] v);
        sb_name.push_back(n);
        sb_val.push_back(v);
    endfunction

    // Queues the full state trace of one instruction, then drains it cycle by cycle.
    task automatic run_instr(input logic [31:0] ir, input int stall);
        logic [4:0]  op;
        logic [52:0] e;
        string       n;
        op = ir[31:27];
        IR = ir;
        Run = 1'b1;
        push("T0", model(ST_T0, ir));
        for (int k = 0; k <= stall; k++) push("T1", model(ST_T1, ir));
        push("T2", model(ST_T2, ir));
        push("T3", model(ST_T3, ir));
        if (tb_alu(op) || tb_md(op)) begin
            push("T4", model(ST_T4, ir));
            push("T5", model(ST_T5, ir));
            if (tb_md(op)) push("T6", model(ST_T6, ir));
            push("IDLE_after", model(ST_IDLE, ir));
        end else begin
            push("HALT", model(ST_HALT, ir));
        end
        for (int i = 0; sb_val.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = sb_val.pop_front();
            n = sb_name.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s ir=%h: got %h expected %h", n, ir, act, e);
            end
            Run = 1'b0;
            Mem_ready = (i >= 1 && i <= stall) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0", act);
        end
        @(posedge clk);
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL reset_held: got %h expected 0", act);
        end
        @(negedge clk);
        Clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL idle_no_run: got %h expected 0", act);
        end
    endtask

    task automatic test_alu_ops();
        run_instr(32'h20918000, 0);
        run_instr(32'h20918000, 3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = {5'b00011, 4'd5, 4'd6, 4'd7, 15'd0};
        b = {5'b01010, 4'd15, 4'd0, 4'd14, 15'h7FFF};
        run_instr(a, 0);
        run_instr(b, 1);
        run_instr(a, 0);
    endtask

    task automatic halt_and_clear(input string tag);
        Run = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (act !== model(ST_HALT, IR)) begin
                errors++;
                $display("FAIL %s_stay: got %h expected %h", tag, act, model(ST_HALT, IR));
            end
        end
        Clear = 1'b0;
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL %s_clear: got %h expected 0", tag, act);
        end
        @(negedge clk);
        Clear = 1'b1;
        Run = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL %s_idle: got %h expected 0", tag, act);
        end
    endtask

    task automatic test_muldiv();
        run_instr(32'h78228000, 0);
`ifndef CTRL_MULDIV_EN
        halt_and_clear("mul_halt");
`endif
        run_instr({5'b10000, 4'd0, 4'd1, 4'd2, 15'd0}, 2);
`ifndef CTRL_MULDIV_EN
        halt_and_clear("div_halt");
`endif
    endtask

    task automatic test_halt();
        run_instr(32'hD8000000, 0);
        halt_and_clear("halt_op");
        run_instr(32'hF8000000, 1);
        halt_and_clear("illegal_op");
    endtask

    task automatic test_clear_mid_t4();
        IR = 32'h20918000;
        Run = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            Run = 1'b0;
        end
        checks++;
        if (act !== model(ST_T4, IR)) begin
            errors++;
            $display("FAIL mid_t4_pre: got %h expected %h", act, model(ST_T4, IR));
        end
        #2;
        Clear = 1'b0;
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL mid_t4_clear: got %h expected 0", act);
        end
        @(posedge clk);
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL mid_t4_held: got %h expected 0", act);
        end
        @(negedge clk);
        Clear = 1'b1;
        run_instr(32'h20918000, 0);
    endtask

    task automatic test_clear_in_t1();
        IR = 32'h20918000;
        Run = 1'b1;
        Mem_ready = 1'b0;
        @(posedge clk);
        #1;
        Run = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (act !== model(ST_T1, IR)) begin
                errors++;
                $display("FAIL t1_hold: got %h expected %h", act, model(ST_T1, IR));
            end
        end
        Clear = 1'b0;
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL t1_clear: got %h expected 0", act);
        end
        @(negedge clk);
        Clear = 1'b1;
        Mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (act !== 53'd0) begin
            errors++;
            $display("FAIL t1_idle: got %h expected 0", act);
        end
    endtask

    initial begin
        Clear = 1'b0;
        Run = 1'b0;
        Mem_ready = 1'b1;
        IR = 32'd0;
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_muldiv();
        test_halt();
        test_clear_mid_t4();
        test_clear_in_t1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
